// File: rtl/codec_job_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// codec_job_scheduler_pkg
// Shared constants and types for the codec job scheduler:
//   - codec mode encodings driven on codec_mode
//   - requester op encodings carried on req_op
//   - scheduler FSM state enum
//   - op_to_mode(): maps a requester op to the codec mode that serves it
// -----------------------------------------------------------------------------
package codec_job_scheduler_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_ENCODE = 3'b001;
  localparam logic [2:0] MODE_DECODE = 3'b010;

  localparam logic OP_ENCODE = 1'b0;
  localparam logic OP_DECODE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_e;

  function automatic logic [2:0] op_to_mode(input logic op);
    return (op == OP_DECODE) ? MODE_DECODE : MODE_ENCODE;
  endfunction

endpackage

// File: rtl/codec_job_scheduler_if.sv
// -----------------------------------------------------------------------------
// codec_job_scheduler_if
// Bundles the requester, codec and response signals of the scheduler.
//   req_valid/req_op/req_data/req_ready : two requesters, valid/ready accept
//   codec_mode/codec_data_in            : scheduler -> codec
//   codec_data_out/codec_done           : codec -> scheduler
//   rsp_valid/rsp_ready/rsp_id/rsp_err/rsp_data : result back to the consumer
// Modports:
//   slave  : the scheduler's view
//   master : the surrounding system (requesters, codec, consumer)
// -----------------------------------------------------------------------------
interface codec_job_scheduler_if #(
  parameter int N = 64
);
  logic [1:0]     req_valid;
  logic [1:0]     req_op;
  logic [2*N-1:0] req_data;
  logic [1:0]     req_ready;

  logic [2:0]     codec_mode;
  logic [N-1:0]   codec_data_in;
  logic [N-1:0]   codec_data_out;
  logic           codec_done;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic           rsp_err;
  logic [N-1:0]   rsp_data;

  modport slave (
    input  req_valid, req_op, req_data, codec_data_out, codec_done, rsp_ready,
    output req_ready, codec_mode, codec_data_in, rsp_valid, rsp_id, rsp_err, rsp_data
  );

  modport master (
    output req_valid, req_op, req_data, codec_data_out, codec_done, rsp_ready,
    input  req_ready, codec_mode, codec_data_in, rsp_valid, rsp_id, rsp_err, rsp_data
  );

endinterface

// File: rtl/codec_job_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// codec_job_scheduler_rr_arbiter2
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request per requester
//   advance  : the current grant is being taken; update the priority pointer
//   gnt      : one-hot grant (all zero when nothing requests)
// The pointer always moves to favour the requester that was not granted, so a
// lone requester also hands priority to the other side.
// -----------------------------------------------------------------------------
module codec_job_scheduler_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;  // requester currently favoured on contention

  // NOTE: always_comb assigns a default first so no path leaves gnt unassigned
  // and a latch cannot be inferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= gnt[0];  // granted 0 -> favour 1 next, granted 1 -> favour 0
    end
  end

endmodule

// File: rtl/codec_job_scheduler.sv
// -----------------------------------------------------------------------------
// codec_job_scheduler
// Shares one ENCODE/DECODE codec between two requesters. Jobs are accepted
// over valid/ready with round-robin arbitration, issued to the codec, and the
// result is returned tagged with the requester id. A per-job timer aborts the
// job with rsp_err=1 if the codec never signals done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : codec_job_scheduler_if.slave (requesters, codec, response)
// Sequence per job: IDLE (grant) -> ISSUE -> WAIT -> RESP -> GAP -> IDLE.
// -----------------------------------------------------------------------------
module codec_job_scheduler
  import codec_job_scheduler_pkg::*;
#(
  parameter int N       = 64,
  parameter int K       = 40,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  codec_job_scheduler_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e        state;
  logic [1:0]    gnt;
  logic          grant;
  logic          sel;
  logic          job_id;
  logic          job_op;
  logic [TW-1:0] timer;

  assign grant = (state == ST_IDLE) && (|bus.req_valid);
  assign sel   = gnt[1];

  // Accept pulse exists only in IDLE, so no job can be taken while one is in flight.
  assign bus.req_ready = (state == ST_IDLE) ? gnt : 2'b00;

  codec_job_scheduler_rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (grant),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      job_id            <= 1'b0;
      job_op            <= OP_ENCODE;
      timer             <= '0;
      bus.codec_mode    <= MODE_IDLE;
      bus.codec_data_in <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.rsp_err       <= 1'b0;
      bus.rsp_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            // Requester inputs are sampled here only; the codec sees them from ISSUE on.
            job_id            <= sel;
            job_op            <= bus.req_op[sel];
            bus.codec_mode    <= op_to_mode(bus.req_op[sel]);
            bus.codec_data_in <= sel ? bus.req_data[2*N-1:N] : bus.req_data[N-1:0];
            state             <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          timer <= (timer == TIMER_MAX) ? timer : timer + 1'b1;
          // done is checked before the timeout so a last-cycle done still succeeds.
          if (bus.codec_done) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= 1'b0;
            bus.rsp_id     <= job_id;
            bus.rsp_data   <= (job_op == OP_DECODE)
                              ? {{(N-K){1'b0}}, bus.codec_data_out[K-1:0]}
                              : bus.codec_data_out;
            bus.codec_mode <= MODE_IDLE;
            state          <= ST_RESP;
          end else if (timer == TIMER_LAST) begin
            // timer holds the count of WAIT cycles already spent, so this is cycle TIMEOUT.
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= 1'b1;
            bus.rsp_id     <= job_id;
            bus.rsp_data   <= '0;
            bus.codec_mode <= MODE_IDLE;
            state          <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_GAP;
          end
        end

        ST_GAP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codec_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_codec_job_scheduler
// Self-checking bench for codec_job_scheduler (N=64, K=40, TIMEOUT=8).
// The codec model builds a codeword {msg[23:0]^24'hA5A5A5, msg[39:0]} and its
// decoder corrects a single flipped bit. Its done pulse arrives in active
// cycle lat+1 counted from the first cycle codec_mode leaves IDLE.
// -----------------------------------------------------------------------------
module tb_codec_job_scheduler;
  import codec_job_scheduler_pkg::*;

  localparam int N       = 64;
  localparam int K       = 40;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  codec_job_scheduler_if #(.N(N)) bus ();

  codec_job_scheduler #(.N(N), .K(K), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- codec model ----------------
  int codec_lat  = 3;
  bit codec_hang = 1'b0;
  int act_cnt    = 0;

  function automatic logic [63:0] model_encode(input logic [39:0] m);
    return {m[23:0] ^ 24'hA5A5A5, m};
  endfunction

  function automatic bit consistent(input logic [63:0] c);
    return c[63:40] == (c[23:0] ^ 24'hA5A5A5);
  endfunction

  function automatic logic [63:0] model_decode(input logic [63:0] c);
    logic [63:0] cand;
    if (consistent(c)) return c;
    for (int j = 0; j < 64; j++) begin
      cand = c ^ (64'd1 << j);
      if (consistent(cand)) return cand;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (bus.codec_mode == 3'b000) begin
      act_cnt        = 0;
      bus.codec_done = 1'b0;
    end else begin
      act_cnt        = act_cnt + 1;
      bus.codec_done = !codec_hang && (act_cnt == codec_lat + 1);
    end
    bus.codec_data_out = (bus.codec_mode == 3'b010) ? model_decode(bus.codec_data_in)
                                                    : model_encode(bus.codec_data_in[39:0]);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset codec_mode",    64'(bus.codec_mode), 64'd0);
    check("reset codec_data_in", bus.codec_data_in, 64'd0);
    check("reset rsp_valid",     64'(bus.rsp_valid), 64'd0);
    check("reset rsp_id/err",    64'({bus.rsp_id, bus.rsp_err}), 64'd0);
    check("reset rsp_data",      bus.rsp_data, 64'd0);
    check("reset req_ready",     64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete job with immediate acceptance of the response.
  task automatic run_job(input int id, input logic op, input logic [63:0] data,
                         input logic [2:0] exp_mode,
                         output logic [63:0] r_data, output logic r_err, output logic r_id,
                         output int mode_cycles, output int bad, output bit ok);
    int waitc;
    ok = 1'b1; mode_cycles = 0; bad = 0; r_data = '0; r_err = 1'b0; r_id = 1'b0;
    @(negedge clk);
    bus.req_valid[id]       = 1'b1;
    bus.req_op[id]          = op;
    bus.req_data[id*N +: N] = data;
    #1;
    waitc = 0;
    while (bus.req_ready[id] !== 1'b1 && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    if (waitc >= 20) begin
      ok = 1'b0;
      bus.req_valid[id] = 1'b0;
      return;
    end
    if (bus.req_ready != (2'b01 << id)) bad++;
    @(negedge clk);
    // Disturb the requester inputs: the job in flight must not see this.
    bus.req_valid[id]       = 1'b0;
    bus.req_op[id]          = ~op;
    bus.req_data[id*N +: N] = ~data;
    #1;
    waitc = 0;
    while (bus.rsp_valid !== 1'b1 && waitc < 40) begin
      if (bus.codec_mode != 3'b000) begin
        mode_cycles++;
        if (bus.codec_mode != exp_mode || bus.codec_data_in != data) bad++;
      end
      @(negedge clk); #1; waitc++;
    end
    if (waitc >= 40) begin
      ok = 1'b0;
      return;
    end
    if (bus.codec_mode != 3'b000) bad++;
    r_data = bus.rsp_data;
    r_err  = bus.rsp_err;
    r_id   = bus.rsp_id;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    // GAP cycle: response gone, codec idle, no grant.
    if (bus.rsp_valid !== 1'b0 || bus.codec_mode != 3'b000) bad++;
  endtask

  typedef struct {
    int          id;
    logic        op;
    logic [63:0] data;
    int          lat;
    bit          hang;
    logic [2:0]  exp_mode;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] r_data;
    logic        r_err, r_id;
    int          mode_cycles, bad, waitc, ng, last_c, gid;
    int          grants[2];
    bit          ok;
    logic [63:0] snap;

    vecs[0] = '{0, 1'b0, 64'h0000_00DD_5486_AA91, 3, 1'b0, 3'b001, 64'h230F_34DD_5486_AA91, 1'b0, 4};
    vecs[1] = '{1, 1'b1, 64'h230F_34DD_5486_AA90, 3, 1'b0, 3'b010, 64'h0000_00DD_5486_AA91, 1'b0, 4};
    vecs[2] = '{0, 1'b0, 64'h0000_0012_3456_7890, 1, 1'b0, 3'b001, 64'hF3DD_3512_3456_7890, 1'b0, 2};
    vecs[3] = '{1, 1'b1, 64'hF3DD_3512_3456_7890, 1, 1'b0, 3'b010, 64'h0000_0012_3456_7890, 1'b0, 2};
    vecs[4] = '{0, 1'b0, 64'h0000_0011_2233_4455, 3, 1'b1, 3'b001, 64'h0,                   1'b1, 9};
    vecs[5] = '{1, 1'b0, 64'h0000_00FF_FFFF_FFFF, 8, 1'b0, 3'b001, 64'h5A5A_5AFF_FFFF_FFFF, 1'b0, 9};
    vecs[6] = '{0, 1'b1, 64'h5A5A_5AFF_FFFF_FFFF, 9, 1'b0, 3'b010, 64'h0,                   1'b1, 9};
    vecs[7] = '{1, 1'b0, 64'h0000_0000_0000_0000, 3, 1'b0, 3'b001, 64'hA5A5_A500_0000_0000, 1'b0, 4};

    do_reset();

    // ---------------- table-driven jobs ----------------
    foreach (vecs[i]) begin
      codec_lat  = vecs[i].lat;
      codec_hang = vecs[i].hang;
      run_job(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].exp_mode,
              r_data, r_err, r_id, mode_cycles, bad, ok);
      check($sformatf("v%0d completed", i),   64'(ok), 64'd1);
      check($sformatf("v%0d rsp_data", i),    r_data, vecs[i].exp_data);
      check($sformatf("v%0d rsp_err", i),     64'(r_err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d rsp_id", i),      64'(r_id), 64'(vecs[i].id));
      check($sformatf("v%0d mode cycles", i), 64'(mode_cycles), 64'(vecs[i].exp_cycles));
      check($sformatf("v%0d protocol", i),    64'(bad), 64'd0);
    end
    codec_hang = 1'b0;
    codec_lat  = 3;

    // ---------------- contention: 3 jobs each, both always valid ----------------
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_data  = {64'h0000_0022_2222_2222, 64'h0000_0011_1111_1111};
    bus.req_valid = 2'b11;
    ng = 0; last_c = 0; grants[0] = 0; grants[1] = 0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        gid = int'(bus.req_ready[1]);
        check($sformatf("contention grant %0d onehot", ng), 64'($countones(bus.req_ready)), 64'd1);
        check($sformatf("contention grant %0d id", ng), 64'(gid), 64'(ng % 2));
        if (ng > 0) check($sformatf("contention grant %0d spacing", ng), 64'(c - last_c), 64'd7);
        last_c = c;
        grants[gid]++;
        ng++;
      end
      @(negedge clk);
      if (grants[0] >= 3) bus.req_valid[0] = 1'b0;
      if (grants[1] >= 3) bus.req_valid[1] = 1'b0;
    end
    check("contention grant total", 64'(ng), 64'd6);
    bus.req_valid = 2'b00;
    repeat (15) @(negedge clk);
    bus.rsp_ready = 1'b0;

    // ---------------- backpressure ----------------
    codec_lat = 2;
    @(negedge clk);
    bus.req_valid[0]    = 1'b1;
    bus.req_op[0]       = 1'b0;
    bus.req_data[63:0]  = 64'h0000_0001_0203_0405;
    #1;
    waitc = 0;
    while (bus.req_ready[0] !== 1'b1 && waitc < 20) begin @(negedge clk); #1; waitc++; end
    check("bp grant", 64'(waitc < 20), 64'd1);
    @(negedge clk);
    bus.req_valid     = 2'b10;
    bus.req_op[1]     = 1'b0;
    bus.req_data[127:64] = 64'h0000_0000_0000_0007;
    #1;
    bad = 0; waitc = 0;
    while (bus.rsp_valid !== 1'b1 && waitc < 40) begin
      if (bus.req_ready != 2'b00) bad++;
      @(negedge clk); #1; waitc++;
    end
    check("bp rsp_data", bus.rsp_data, 64'hA6A1_A001_0203_0405);
    check("bp rsp_id/err", 64'({bus.rsp_id, bus.rsp_err}), 64'd0);
    snap = bus.rsp_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || bus.rsp_id !== 1'b0 ||
          bus.rsp_err !== 1'b0 || bus.req_ready != 2'b00 || bus.codec_mode != 3'b000) bad++;
    end
    check("bp held stable", 64'(bad), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp gap rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp gap no grant",  64'(bus.req_ready), 64'd0);
    @(negedge clk); #1;
    check("bp grant after gap", 64'(bus.req_ready), 64'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (12) @(negedge clk);
    bus.rsp_ready = 1'b0;

    // ---------------- reset mid-WAIT ----------------
    codec_hang = 1'b1;
    bus.req_valid[0]   = 1'b1;
    bus.req_op[0]      = 1'b1;
    bus.req_data[63:0] = 64'h1234_5678_9ABC_DEF0;
    #1;
    waitc = 0;
    while (bus.req_ready[0] !== 1'b1 && waitc < 20) begin @(negedge clk); #1; waitc++; end
    check("rst-mid grant", 64'(waitc < 20), 64'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst-mid codec_mode",    64'(bus.codec_mode), 64'd0);
    check("rst-mid codec_data_in", bus.codec_data_in, 64'd0);
    check("rst-mid rsp_valid",     64'(bus.rsp_valid), 64'd0);
    check("rst-mid rsp_data",      bus.rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    codec_hang = 1'b0;
    codec_lat  = 3;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 1'b0) bad++;
    end
    check("rst-mid no response", 64'(bad), 64'd0);
    run_job(1, 1'b0, 64'h0000_00AB_CDEF_0123, 3'b001, r_data, r_err, r_id, mode_cycles, bad, ok);
    check("post-rst completed", 64'(ok), 64'd1);
    check("post-rst rsp_data",  r_data, 64'h4AA4_86AB_CDEF_0123);
    check("post-rst rsp_id/err", 64'({r_id, r_err}), 64'b10);
    check("post-rst protocol",  64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
